// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module : data_ram_resp
// Brief  : MEM-stage data-memory responder with wait states and stall request
// Rev    : 1.0  initial release
// ============================================================================
module data_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_req_o
);

  localparam int         c_DEPTH    = 1 << ADDR_W;
  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WAIT     = 2'd1;
  localparam logic [1:0] c_RESP     = 2'd2;
  localparam bit         c_NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_CNT_INIT = c_NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0]       r_mem [0:c_DEPTH-1];
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_oor;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic              r_ack;
  logic              r_err;

  logic              w_idle;
  logic              w_in_oor;
  logic [ADDR_W-1:0] w_in_idx;
  logic              w_we;
  logic              w_oor;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdata;
  logic              w_enter_resp;
  logic              w_unused_addr;

  // Byte offset within the word is carried by sel_i, so addr_i[1:0] is dropped.
  assign w_unused_addr = ^addr_i[1:0];
  assign w_in_oor      = |addr_i[31:ADDR_W+2];
  assign w_in_idx      = addr_i[ADDR_W+1:2];
  assign w_idle        = (r_state == c_IDLE);

  // With zero wait states the access happens on the capture edge, so live inputs are used.
  always_comb begin
    w_we    = r_we;
    w_oor   = r_oor;
    w_idx   = r_idx;
    w_sel   = r_sel;
    w_wdata = r_wdata;
    if (w_idle) begin
      w_we    = we_i;
      w_oor   = w_in_oor;
      w_idx   = w_in_idx;
      w_sel   = sel_i;
      w_wdata = data_i;
    end
  end

  assign w_enter_resp = (w_idle && ce_i && c_NO_WAIT) ||
                        ((r_state == c_WAIT) && (r_cnt == 4'd0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
      r_data  <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (ce_i) begin
            if (c_NO_WAIT) begin
              r_state <= c_RESP;
            end else begin
              r_state <= c_WAIT;
              r_cnt   <= c_CNT_INIT;
            end
          end
        end
        c_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
      if (w_enter_resp) begin
        r_ack <= 1'b1;
        r_err <= w_oor;
        if (!w_we) begin
          r_data <= w_oor ? 32'd0 : r_mem[w_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle && ce_i) begin
      r_we    <= we_i;
      r_oor   <= w_in_oor;
      r_idx   <= w_in_idx;
      r_sel   <= sel_i;
      r_wdata <= data_i;
    end
  end

  // Array is deliberately not reset; a write only lands on a clean RESP entry.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && w_we && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_sel[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_o      = r_data;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign stall_req_o = rst && ((w_idle && ce_i) || (r_state == c_WAIT));

endmodule
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_data_ram_resp
// Brief  : Directed vector bench for data_ram_resp (WAIT_CYCLES=2 and =0)
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce2, ce0;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] data2, data0;
  logic        ack2, ack0, err2, err0, stall2, stall0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .ce_i(ce2), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(data2), .ack_o(ack2), .err_o(err2), .stall_req_o(stall2)
  );

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(data0), .ack_o(ack0), .err_o(err0), .stall_req_o(stall0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One request; returns after the ack cycle with ce dropped.
  task automatic do_req(input bit use0, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee, input string nm);
    int          lat;
    int          ack_at;
    logic [15:0] smask;
    logic [31:0] got_d;
    logic        got_e;
    lat    = use0 ? 0 : 2;
    ack_at = -1;
    smask  = '0;
    got_d  = '0;
    got_e  = 1'b0;
    @(negedge clk);
    we = w; addr = a; sel = s; wdata = d;
    if (use0) ce0 = 1'b1; else ce2 = 1'b1;
    for (int c = 0; c < 16 && ack_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (use0 ? stall0 : stall2) smask[c] = 1'b1;
      if (use0 ? ack0 : ack2) begin
        ack_at = c;
        got_d  = use0 ? data0 : data2;
        got_e  = use0 ? err0 : err2;
        ce0 = 1'b0;
        ce2 = 1'b0;
      end
    end
    ce0 = 1'b0;
    ce2 = 1'b0;
    chk({nm, " ack_cycle"}, 32'(ack_at), 32'(lat + 1));
    chk({nm, " stall_mask"}, 32'(smask), 32'((1 << (lat + 1)) - 1));
    chk({nm, " err"}, 32'(got_e), 32'(ee));
    chk({nm, " data"}, got_d, ed);
  endtask

  initial begin
    int  ack_at;
    bit  ack_seen;

    tbl[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0102_0304, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0020, 4'h4, 32'h00AA_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        32'h11AA_3344, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 32'h11AA_3344, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        32'h11AA_3344, 1'b0};
    tbl[8]  = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,        32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,        32'h0000_0000, 1'b1};
    tbl[11] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,        32'h0102_0304, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0FFF, 4'hF, 32'hA5A5_A5A5, 32'h0102_0304, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,        32'hA5A5_A5A5, 1'b0};
    tbl[14] = '{1'b1, 32'h0000_0030, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    tbl[15] = '{1'b1, 32'h0000_0040, 4'hF, 32'h55AA_55AA, 32'hA5A5_A5A5, 1'b0};

    rst = 1'b0; ce2 = 1'b0; ce0 = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ce2 = 1'b1;
    #1;
    chk("reset stall forced low", 32'(stall2), 32'd0);
    @(negedge clk);
    ce2 = 1'b0;
    #1;
    chk("reset data_o", data2, 32'd0);
    chk("reset ack/err", {30'd0, ack2, err2}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].data,
             tbl[i].exp_d, tbl[i].exp_e, $sformatf("vec%0d", i));
    end

    // Inputs changed mid-WAIT: captured read address must be used.
    @(negedge clk);
    we = 1'b0; addr = 32'h40; sel = 4'hF; ce2 = 1'b1;
    ack_at = -1;
    for (int c = 0; c < 10 && ack_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        ce2 = 1'b0; we = 1'b1; addr = 32'h10; wdata = 32'h0;
      end
      #1;
      if (ack2) begin
        ack_at = c;
        chk("wait_change data", data2, 32'h55AA_55AA);
      end
    end
    chk("wait_change ack_cycle", 32'(ack_at), 32'd3);
    do_req(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, "wait_change no_write");

    // Reset during WAIT of a write: never acked, never committed.
    @(negedge clk);
    we = 1'b1; addr = 32'h30; sel = 4'hF; wdata = 32'h7777_7777; ce2 = 1'b1;
    @(negedge clk);
    ce2 = 1'b0; rst = 1'b0;
    #1;
    chk("rst_mid stall", 32'(stall2), 32'd0);
    ack_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (ack2) ack_seen = 1'b1;
    end
    chk("rst_mid no_ack", 32'(ack_seen), 32'd0);
    rst = 1'b1;
    do_req(1'b0, 1'b0, 32'h30, 4'hF, 32'h0, 32'h0, 1'b0, "rst_mid read");

    // Zero wait states.
    do_req(1'b1, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, "w0 wr0");
    do_req(1'b1, 1'b1, 32'h4, 4'hF, 32'h1234_5678, 32'h0, 1'b0, "w0 wr4");
    @(negedge clk);
    we = 1'b0; addr = 32'h0; sel = 4'hF; ce0 = 1'b1;
    #1;
    chk("b2b c0 stall/ack", {30'd0, stall0, ack0}, 32'b10);
    @(negedge clk);
    #1;
    chk("b2b c1 stall/ack", {30'd0, stall0, ack0}, 32'b01);
    chk("b2b c1 data", data0, 32'h0BAD_F00D);
    addr = 32'h4;
    @(negedge clk);
    #1;
    chk("b2b c2 stall/ack", {30'd0, stall0, ack0}, 32'b10);
    @(negedge clk);
    #1;
    chk("b2b c3 stall/ack", {30'd0, stall0, ack0}, 32'b01);
    chk("b2b c3 data", data0, 32'h1234_5678);
    ce0 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
